core_fetch_pc_gen: RTL and testbench
====================================

// Module: core_fetch_pc_gen
// PURPOSE
//  Parametrised fetch-address generator for each ring-network core; successor to the single-width PC block.
//  Holds the PC and selects the next PC by priority: execute redirect, decode redirect, BTB prediction,
//  internal return-address stack (RAS), sequential.
//  Presents the PC to the I-cache through a valid/ready handshake. Supports halt/resume for core quiescing.
// PARAMETERS
//  AW          32            address width (bits)
//  RESET_ADDR  32'h00040000  PC value after reset (AW bits)
//  INST_BYTES  4             sequential increment
//  RAS_DEPTH   8             RAS entries, power of 2, >=2
//  RAS_CW      4             RAS count width = log2(RAS_DEPTH)+1
// PORTS
//  clk          in   1       clock, all state on rising edge
//  rst          in   1       reset, synchronous, active-high
//  ex_redirect  in   1       execute-stage mispredict; highest priority
//  ex_target    in   AW      correct target from execute
//  id_redirect  in   1       decode-stage redirect
//  id_target    in   AW      correct target from decode
//  btb_v        in   1       BTB hit for current pc_out
//  btb_type     in   2       00 br, 01 j, 10 jal, 11 jr
//  btb_target   in   AW      predicted target (br/j/jal)
//  pc_ready     in   1       I-cache accepts pc_out this cycle
//  halt         in   1       request halt (level)
//  pc_out       out  AW      fetch address
//  pc_valid     out  1       pc_out valid for fetch
//  pc_plus      out  AW      pc_out + INST_BYTES (combinational, wraps mod 2^AW)
//  ras_cnt      out  RAS_CW  valid RAS entries
//  halted       out  1       block is in HALT state
// BEHAVIOUR
//  Reset: pc_out=RESET_ADDR, pc_valid=0, ras_cnt=0, halted=0, state=BOOT. Reset mid-operation discards all state.
//  FSM: BOOT -> RUN after 1 cycle.
//   RUN -> HALT when halt=1 and no redirect that cycle.
//   HALT -> RUN when halt=0, or on any redirect.
//  pc_valid=1 only in RUN. halted=1 only in HALT.
//  accept = pc_valid & pc_ready.
//  Next-PC priority, registered, 1-cycle latency:
//   1. ex_redirect: pc<=ex_target; RAS cleared (ras_cnt<=0). Ignores ready, state, halt.
//   2. id_redirect (no ex_redirect): pc<=id_target; RAS untouched.
//   3. accept & btb_v & type 00/01: pc<=btb_target.
//   4. accept & btb_v & type 10 (jal): pc<=btb_target; push pc_plus.
//   5. accept & btb_v & type 11 (jr): if ras_cnt>0, pc<=RAS top and pop; else pc<=pc_plus.
//   6. accept, no hit: pc<=pc_plus.
//   7. otherwise (no accept, no redirect): pc, RAS hold.
//  Redirect in BOOT or HALT: load pc; state<=RUN.
//  Redirect the same cycle as an accept: the redirect wins; no push/pop occurs.
//  RAS is circular, top pointer mod RAS_DEPTH:
//   push when full overwrites oldest; ras_cnt saturates at RAS_DEPTH.
//   pop when empty: no pointer change, falls through as rule 5.
//  Width: all adds truncate to AW; 32'hFFFFFFFC + 4 -> 0.
// TESTING
//  T1 reset: rst 2 cycles -> pc_out=0x00040000, pc_valid=0, ras_cnt=0; next cycle pc_valid=1.
//  T2 sequential: pc_ready=1 for 3 cycles -> 0x40000,0x40004,0x40008.
//     pc_ready=0 -> pc_out holds 0x40008.
//  T3 call/return: at 0x40008 jal hit, target 0x50000 -> pc=0x50000, ras_cnt=1.
//     jr hit at 0x50010 -> pc=0x4000C, ras_cnt=0.
//     Further jr with empty RAS -> pc_plus.
//  T4 overflow: 9 jal pushes, RAS_DEPTH=8 -> ras_cnt=8; 8 pops return the 8 newest addresses, then fall through.
//  T5 priority: same cycle ex_redirect(0x60000) + id_redirect(0x70000) + jal hit -> pc=0x60000, ras_cnt=0.
//     id_redirect alone -> pc=0x70000, ras_cnt unchanged.
//  T6 halt: halt=1 -> next cycle pc_valid=0, halted=1, pc held.
//     halt=0 -> pc_valid=1 at the same pc. id_redirect while halted -> RUN at id_target.

Source files
------------

// File: rtl/core_fetch_pc_gen.sv
// core_fetch_pc_gen: prioritised next-PC selection with a circular return-address stack and halt/resume FSM
module core_fetch_pc_gen #(
  parameter int AW = 32,
  parameter logic [AW-1:0] RESET_ADDR = AW'(32'h00040000),
  parameter int INST_BYTES = 4,
  parameter int RAS_DEPTH = 8,
  parameter int RAS_CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ex_redirect,
  input  logic [AW-1:0] ex_target,
  input  logic          id_redirect,
  input  logic [AW-1:0] id_target,
  input  logic          btb_v,
  input  logic [1:0]    btb_type,
  input  logic [AW-1:0] btb_target,
  input  logic          pc_ready,
  input  logic          halt,
  output logic [AW-1:0] pc_out,
  output logic          pc_valid,
  output logic [AW-1:0] pc_plus,
  output logic [RAS_CW-1:0] ras_cnt,
  output logic          halted
);
  localparam int PW = RAS_CW - 1;
  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
  state_t state, st_nxt;
  logic [AW-1:0] ras [RAS_DEPTH];
  logic [PW-1:0] tp;
  logic redir, accept, hit, push, pop;
  logic [AW-1:0] pc_nxt;
  assign pc_plus = pc_out + AW'(INST_BYTES);
  assign redir = ex_redirect | id_redirect;
  assign accept = pc_valid & pc_ready;
  // a redirect in the same cycle suppresses any BTB-driven push/pop
  assign hit = accept & btb_v & ~redir;
  assign push = hit & (btb_type == 2'b10);
  assign pop = hit & (btb_type == 2'b11) & (ras_cnt != '0);
  always_comb begin
    pc_nxt = ex_redirect ? ex_target :
             id_redirect ? id_target :
             pop ? ras[tp] :
             (push | (hit & ~btb_type[1])) ? btb_target :
             accept ? pc_plus : pc_out;
    st_nxt = state == BOOT ? RUN :
             state == RUN ? ((halt & ~redir) ? HALT : RUN) :
             ((~halt | redir) ? RUN : HALT);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= BOOT;
      pc_out <= RESET_ADDR;
      pc_valid <= 1'b0;
      halted <= 1'b0;
      ras_cnt <= '0;
      tp <= '0;
    end else begin
      state <= st_nxt;
      pc_out <= pc_nxt;
      pc_valid <= st_nxt == RUN;
      halted <= st_nxt == HALT;
      if (ex_redirect) ras_cnt <= '0;
      else if (push) begin
        // the pointer wraps, so a push when full overwrites the oldest entry
        ras_cnt <= (ras_cnt == RAS_CW'(RAS_DEPTH)) ? ras_cnt : ras_cnt + 1'b1;
        tp <= tp + 1'b1;
        ras[tp + 1'b1] <= pc_plus;
      end else if (pop) begin
        ras_cnt <= ras_cnt - 1'b1;
        tp <= tp - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_core_fetch_pc_gen.sv
// tb_core_fetch_pc_gen: scoreboard bench driving stimulus rows and checking registered PC/RAS/FSM results
module tb_core_fetch_pc_gen;
  logic clk = 0, rst = 1, ex_redirect = 0, id_redirect = 0, btb_v = 0, pc_ready = 0, halt = 0;
  logic [31:0] ex_target = 0, id_target = 0, btb_target = 0;
  logic [1:0] btb_type = 0;
  logic [31:0] pc_out, pc_plus;
  logic pc_valid, halted;
  logic [3:0] ras_cnt;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  core_fetch_pc_gen dut (
    .clk(clk), .rst(rst), .ex_redirect(ex_redirect), .ex_target(ex_target),
    .id_redirect(id_redirect), .id_target(id_target), .btb_v(btb_v), .btb_type(btb_type),
    .btb_target(btb_target), .pc_ready(pc_ready), .halt(halt), .pc_out(pc_out),
    .pc_valid(pc_valid), .pc_plus(pc_plus), .ras_cnt(ras_cnt), .halted(halted)
  );
  typedef struct {
    string nm;
    logic r, ex, id, bv, rdy, hlt;
    logic [31:0] ext, idt, tgt;
    logic [1:0] bt;
    logic [31:0] pc;
    logic v, h;
    logic [3:0] cnt;
  } row_t;
  row_t sb[$];
  function automatic row_t row(string nm, logic r, logic ex, logic [31:0] ext, logic id, logic [31:0] idt,
                               logic bv, logic [1:0] bt, logic [31:0] tgt, logic rdy, logic hlt,
                               logic [31:0] pc, logic v, logic [3:0] cnt, logic h);
    row_t x;
    x.nm = nm; x.r = r; x.ex = ex; x.ext = ext; x.id = id; x.idt = idt; x.bv = bv; x.bt = bt;
    x.tgt = tgt; x.rdy = rdy; x.hlt = hlt; x.pc = pc; x.v = v; x.cnt = cnt; x.h = h;
    return x;
  endfunction
  task automatic apply(input row_t x);
    rst = x.r; ex_redirect = x.ex; ex_target = x.ext; id_redirect = x.id; id_target = x.idt;
    btb_v = x.bv; btb_type = x.bt; btb_target = x.tgt; pc_ready = x.rdy; halt = x.hlt;
    sb.push_back(x);
  endtask
  task automatic test_reset;
    row_t rs[$];
    row_t e;
    rs.push_back(row("reset1", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h40000, 0, 0, 0));
    rs.push_back(row("reset2", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h40000, 0, 0, 0));
    rs.push_back(row("boot_run", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h40000, 1, 0, 0));
    foreach (rs[i]) begin
      apply(rs[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ({pc_out, pc_valid, ras_cnt, halted} !== {e.pc, e.v, e.cnt, e.h}) begin
        errors++;
        $display("FAIL %s: got pc=%h v=%b cnt=%0d h=%b, want pc=%h v=%b cnt=%0d h=%b",
                 e.nm, pc_out, pc_valid, ras_cnt, halted, e.pc, e.v, e.cnt, e.h);
      end
    end
  endtask
  task automatic test_sequential;
    row_t rs[$];
    row_t e;
    rs.push_back(row("seq1", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h40004, 1, 0, 0));
    rs.push_back(row("seq2", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h40008, 1, 0, 0));
    rs.push_back(row("hold1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h40008, 1, 0, 0));
    rs.push_back(row("hold2", 0, 0, 0, 0, 0, 1, 2'b10, 32'h55000, 0, 0, 32'h40008, 1, 0, 0));
    foreach (rs[i]) begin
      apply(rs[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ({pc_out, pc_valid, ras_cnt, halted} !== {e.pc, e.v, e.cnt, e.h}) begin
        errors++;
        $display("FAIL %s: got pc=%h v=%b cnt=%0d h=%b, want pc=%h v=%b cnt=%0d h=%b",
                 e.nm, pc_out, pc_valid, ras_cnt, halted, e.pc, e.v, e.cnt, e.h);
      end
    end
    checks++;
    if (pc_plus !== 32'h4000C) begin
      errors++;
      $display("FAIL pc_plus: got %h, want %h", pc_plus, 32'h4000C);
    end
  endtask
  task automatic test_call_return;
    row_t rs[$];
    row_t e;
    rs.push_back(row("jal", 0, 0, 0, 0, 0, 1, 2'b10, 32'h50000, 1, 0, 32'h50000, 1, 1, 0));
    for (int i = 1; i <= 4; i++)
      rs.push_back(row($sformatf("walk%0d", i), 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h50000 + 32'(4 * i), 1, 1, 0));
    rs.push_back(row("jr_noacc", 0, 0, 0, 0, 0, 1, 2'b11, 0, 0, 0, 32'h50010, 1, 1, 0));
    rs.push_back(row("jr_pop", 0, 0, 0, 0, 0, 1, 2'b11, 0, 1, 0, 32'h4000C, 1, 0, 0));
    rs.push_back(row("jr_empty", 0, 0, 0, 0, 0, 1, 2'b11, 0, 1, 0, 32'h40010, 1, 0, 0));
    rs.push_back(row("br", 0, 0, 0, 0, 0, 1, 2'b00, 32'h80000, 1, 0, 32'h80000, 1, 0, 0));
    rs.push_back(row("j", 0, 0, 0, 0, 0, 1, 2'b01, 32'h90000, 1, 0, 32'h90000, 1, 0, 0));
    foreach (rs[i]) begin
      apply(rs[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ({pc_out, pc_valid, ras_cnt, halted} !== {e.pc, e.v, e.cnt, e.h}) begin
        errors++;
        $display("FAIL %s: got pc=%h v=%b cnt=%0d h=%b, want pc=%h v=%b cnt=%0d h=%b",
                 e.nm, pc_out, pc_valid, ras_cnt, halted, e.pc, e.v, e.cnt, e.h);
      end
    end
  endtask
  task automatic test_overflow;
    row_t rs[$];
    row_t e;
    for (int i = 0; i < 9; i++)
      rs.push_back(row($sformatf("push%0d", i), 0, 0, 0, 0, 0, 1, 2'b10, 32'hA0000 + 32'(i * 256), 1, 0,
                       32'hA0000 + 32'(i * 256), 1, 4'((i < 8) ? i + 1 : 8), 0));
    for (int j = 0; j < 8; j++)
      rs.push_back(row($sformatf("pop%0d", j), 0, 0, 0, 0, 0, 1, 2'b11, 0, 1, 0,
                       32'hA0004 + 32'((7 - j) * 256), 1, 4'(7 - j), 0));
    rs.push_back(row("pop_empty", 0, 0, 0, 0, 0, 1, 2'b11, 0, 1, 0, 32'hA0008, 1, 0, 0));
    foreach (rs[i]) begin
      apply(rs[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ({pc_out, pc_valid, ras_cnt, halted} !== {e.pc, e.v, e.cnt, e.h}) begin
        errors++;
        $display("FAIL %s: got pc=%h v=%b cnt=%0d h=%b, want pc=%h v=%b cnt=%0d h=%b",
                 e.nm, pc_out, pc_valid, ras_cnt, halted, e.pc, e.v, e.cnt, e.h);
      end
    end
  endtask
  task automatic test_priority;
    row_t rs[$];
    row_t e;
    rs.push_back(row("pre_jal", 0, 0, 0, 0, 0, 1, 2'b10, 32'hB0000, 1, 0, 32'hB0000, 1, 1, 0));
    rs.push_back(row("ex_wins", 0, 1, 32'h60000, 1, 32'h70000, 1, 2'b10, 32'hC0000, 1, 0, 32'h60000, 1, 0, 0));
    rs.push_back(row("jal2", 0, 0, 0, 0, 0, 1, 2'b10, 32'h61000, 1, 0, 32'h61000, 1, 1, 0));
    rs.push_back(row("id_wins", 0, 0, 0, 1, 32'h70000, 1, 2'b11, 0, 1, 0, 32'h70000, 1, 1, 0));
    rs.push_back(row("ras_kept", 0, 0, 0, 0, 0, 1, 2'b11, 0, 1, 0, 32'h60004, 1, 0, 0));
    rs.push_back(row("ex_noready", 0, 1, 32'h62000, 0, 0, 0, 0, 0, 0, 0, 32'h62000, 1, 0, 0));
    foreach (rs[i]) begin
      apply(rs[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ({pc_out, pc_valid, ras_cnt, halted} !== {e.pc, e.v, e.cnt, e.h}) begin
        errors++;
        $display("FAIL %s: got pc=%h v=%b cnt=%0d h=%b, want pc=%h v=%b cnt=%0d h=%b",
                 e.nm, pc_out, pc_valid, ras_cnt, halted, e.pc, e.v, e.cnt, e.h);
      end
    end
  endtask
  task automatic test_halt;
    row_t rs[$];
    row_t e;
    rs.push_back(row("halt_req", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h62000, 0, 0, 1));
    rs.push_back(row("halt_hold", 0, 0, 0, 0, 0, 1, 2'b10, 32'hD0000, 1, 1, 32'h62000, 0, 0, 1));
    rs.push_back(row("resume", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h62000, 1, 0, 0));
    rs.push_back(row("halt_again", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h62000, 0, 0, 1));
    rs.push_back(row("id_in_halt", 0, 0, 0, 1, 32'h71000, 0, 0, 0, 0, 1, 32'h71000, 1, 0, 0));
    rs.push_back(row("rehalt", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h71000, 0, 0, 1));
    rs.push_back(row("ex_in_halt", 0, 1, 32'h72000, 0, 0, 0, 0, 0, 0, 1, 32'h72000, 1, 0, 0));
    rs.push_back(row("run_on", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h72004, 1, 0, 0));
    foreach (rs[i]) begin
      apply(rs[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ({pc_out, pc_valid, ras_cnt, halted} !== {e.pc, e.v, e.cnt, e.h}) begin
        errors++;
        $display("FAIL %s: got pc=%h v=%b cnt=%0d h=%b, want pc=%h v=%b cnt=%0d h=%b",
                 e.nm, pc_out, pc_valid, ras_cnt, halted, e.pc, e.v, e.cnt, e.h);
      end
    end
  endtask
  task automatic test_wrap_and_mid_reset;
    row_t rs[$];
    row_t e;
    rs.push_back(row("to_top", 0, 1, 32'hFFFFFFFC, 0, 0, 0, 0, 0, 0, 0, 32'hFFFFFFFC, 1, 0, 0));
    rs.push_back(row("wrap", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0, 1, 0, 0));
    rs.push_back(row("jal0", 0, 0, 0, 0, 0, 1, 2'b10, 32'h100, 1, 0, 32'h100, 1, 1, 0));
    rs.push_back(row("mid_rst", 1, 0, 0, 0, 0, 1, 2'b11, 0, 1, 0, 32'h40000, 0, 0, 0));
    rs.push_back(row("boot_id", 0, 0, 0, 1, 32'h12340, 0, 0, 0, 0, 0, 32'h12340, 1, 0, 0));
    rs.push_back(row("ras_gone", 0, 0, 0, 0, 0, 1, 2'b11, 0, 1, 0, 32'h12344, 1, 0, 0));
    foreach (rs[i]) begin
      apply(rs[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ({pc_out, pc_valid, ras_cnt, halted} !== {e.pc, e.v, e.cnt, e.h}) begin
        errors++;
        $display("FAIL %s: got pc=%h v=%b cnt=%0d h=%b, want pc=%h v=%b cnt=%0d h=%b",
                 e.nm, pc_out, pc_valid, ras_cnt, halted, e.pc, e.v, e.cnt, e.h);
      end
      if (i == 0) begin
        checks++;
        if (pc_plus !== 32'h0) begin
          errors++;
          $display("FAIL pc_plus_wrap: got %h, want %h", pc_plus, 32'h0);
        end
      end
    end
  endtask
  initial begin
    test_reset;
    test_sequential;
    test_call_return;
    test_overflow;
    test_priority;
    test_halt;
    test_wrap_and_mid_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
